uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter peripheral on the `rv32i` data bus, alongside `mem`. The core writes bytes to a DATA register; they are buffered in a small FIFO and serialized LSB-first onto `o_Tx` as 8N1 frames. A STATUS register exposes busy, full, empty, overflow and the FIFO count so firmware can poll before writing. This is the outbound counterpart to the receive path on `i_Rx`.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH`, 8: byte FIFO entries. Power of two, 2–16.
- `BASE_ADDR`, 16'hFF00: DATA register address. STATUS is at `BASE_ADDR + 4`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `WE` in 1: bus write enable from the core.
- `address` in 16: bus byte address.
- `writeData` in 32: bus write data.
- `readData` out 32: combinational read data. Zero when `address` matches neither register.
- `o_Tx` out 1: serial line. Idles high.
- `o_busy` out 1: high while a frame is on the line or the FIFO is non-empty.

## Operation
- **DATA write** (`WE` and `address == BASE_ADDR`): pushes `writeData[7:0]`. If the FIFO is full (sampled before the edge), the byte is dropped and sticky `ovf` is set. This holds even if a pop occurs on the same edge.
- **DATA read**: returns 0.
- **STATUS read**: `{24'b0, count[3:0], ovf, empty, full, busy}`.
  - `busy` is the same signal as `o_busy`.
  - `count` is the FIFO occupancy.
- **STATUS write** with `writeData[3] = 1`: clears `ovf`. Other bits are ignored.
- Simultaneous push and pop on a non-full FIFO: both happen; `count` is unchanged.
- **FSM states:** IDLE, START, DATA, STOP (PARITY when enabled).
  - IDLE → START when FIFO is non-empty. The byte is popped into the shift register on the same edge.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA runs 8 bits, LSB first, `CLKS_PER_BIT` cycles each, then → STOP.
  - STOP lasts `CLKS_PER_BIT` cycles. At its end: → START with a pop if the FIFO is non-empty, otherwise → IDLE.
- Bit counter: 3 bits, wraps 7 → 0 on the DATA exit.
- Baud counter: reloads to 0 on every state change.
- **Reset** (`rst_n` low at an edge), including mid-frame:
  - `o_Tx = 1`, `o_busy = 0`, FIFO empty, `count = 0`, `ovf = 0`, FSM in IDLE.
  - The partial frame is abandoned.
  - `readData` STATUS value after reset: `32'h4` (empty only).

## Timing
- Write to an empty FIFO with the FSM in IDLE at edge N:
  - `count = 1` after N.
  - Pop at edge N+1; `o_Tx` falls to 0 after N+1.
- Each bit is held exactly `CLKS_PER_BIT` cycles. A full 8N1 frame is `10*CLKS_PER_BIT` cycles.
- Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- `o_busy` rises the cycle after the first push and falls the cycle after the last stop bit completes with the FIFO empty.
- `readData` has zero latency: it is combinational from `address` and the current registers.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - Inserts a PARITY state between DATA and STOP, sending even parity (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
  - Frame is 8E1, 11 bit-times.
  - STATUS bit 8 reads 1 to advertise parity.
- Not defined:
  - 8N1, 10 bit-times.
  - No PARITY state or logic; STATUS bit 8 reads 0.

## Test plan
All scenarios use `CLKS_PER_BIT = 4`, `FIFO_DEPTH = 4`.
- **Reset:** hold `rst_n = 0` for 3 cycles → `o_Tx = 1`, `o_busy = 0`; STATUS read = `32'h4`.
- **Single byte:** write 8'hA5 to DATA → `o_Tx` sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each held 4 cycles, starting 1 cycle after the write; `o_busy` low 41 cycles after the write.
- **Back-to-back:** write 8'h01 then 8'h02 on consecutive cycles → two 40-cycle frames with no gap; STATUS `count` reads 1 after the first pop and 0 after the second.
- **Overflow:** with the FSM in IDLE, write 6 bytes on consecutive cycles → 5 accepted (1 popped immediately + 4 buffered), the 6th dropped; STATUS = `{count=4, ovf=1, full=1, busy=1}`; writing STATUS with `32'h8` clears `ovf`.
- **Reset mid-frame:** assert `rst_n = 0` during data bit 3 of 8'hFF → `o_Tx = 1` after that edge; after release, no residual frame and STATUS = `32'h4`.
- **Parity (`UART_TX_PARITY_EN`):** write 8'h07 → parity bit = 1, frame is 44 cycles, STATUS bit 8 = 1.

Source files
------------

// File: rtl/uart_tx_mmio_if.sv
// Bus-side signal bundle for the memory-mapped UART transmitter.
// The core drives the master side; the peripheral implements the slave side.
interface uart_tx_mmio_if;
    logic        WE;
    logic [15:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;

    modport master (
        output WE,
        output address,
        output writeData,
        input  readData
    );

    modport slave (
        input  WE,
        input  address,
        input  writeData,
        output readData
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: DATA register feeds a byte FIFO drained LSB-first onto o_Tx.
// Optional even parity bit (8E1 frames) when UART_TX_PARITY_EN is defined.
module uart_tx_mmio #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] BASE_ADDR    = 16'hFF00
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_mmio_if.slave  bus,
    output logic           o_Tx,
    output logic           o_busy
);

    localparam int          PW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW          = $clog2(FIFO_DEPTH + 1);
    localparam int          BW          = $clog2(CLKS_PER_BIT);
    localparam logic [15:0] STATUS_ADDR = BASE_ADDR + 16'd4;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    localparam logic PARITY_FLAG = 1'b1;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
    localparam logic PARITY_FLAG = 1'b0;
`endif

    state_t          state_reg;
    logic [BW-1:0]   baud_reg;
    logic [2:0]      bit_reg;
    logic [7:0]      shift_reg;
    logic            tx_reg;
`ifdef UART_TX_PARITY_EN
    logic            parity_reg;
`endif

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            ovf_reg;

    logic            data_sel;
    logic            status_sel;
    logic            push_req;
    logic            push_ok;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            baud_end;
    logic [7:0]      head_byte;
    logic [7:0]      count_ext;
    logic [31:0]     status_word;
    logic            unused_bits;

    always_comb begin
        data_sel   = (bus.address == BASE_ADDR);
        status_sel = (bus.address == STATUS_ADDR);
        push_req   = bus.WE && data_sel;
        fifo_full  = (count_reg == CW'(FIFO_DEPTH));
        fifo_empty = (count_reg == '0);
        push_ok    = push_req && !fifo_full;
        baud_end   = (baud_reg == BW'(CLKS_PER_BIT - 1));
        // The FSM takes a byte either from idle or right at the end of a stop bit,
        // which is what gives zero-gap back-to-back frames.
        pop        = !fifo_empty &&
                     ((state_reg == S_IDLE) || ((state_reg == S_STOP) && baud_end));
        head_byte  = mem[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= bus.writeData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            // Fullness is judged before the edge, so a same-cycle pop does not rescue the byte.
            if (push_req && fifo_full) begin
                ovf_reg <= 1'b1;
            end else if (bus.WE && status_sel && bus.writeData[3]) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            tx_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    baud_reg <= '0;
                    tx_reg   <= 1'b1;
                    if (pop) begin
                        shift_reg  <= head_byte;
`ifdef UART_TX_PARITY_EN
                        parity_reg <= ^head_byte;
`endif
                        tx_reg     <= 1'b0;
                        state_reg  <= S_START;
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        baud_reg  <= '0;
                        bit_reg   <= '0;
                        tx_reg    <= shift_reg[0];
                        state_reg <= S_DATA;
                    end else begin
                        baud_reg <= baud_reg + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud_reg <= '0;
                        bit_reg  <= bit_reg + 3'd1;
                        if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_reg    <= parity_reg;
                            state_reg <= S_PARITY;
`else
                            tx_reg    <= 1'b1;
                            state_reg <= S_STOP;
`endif
                        end else begin
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx_reg    <= shift_reg[1];
                        end
                    end else begin
                        baud_reg <= baud_reg + BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_end) begin
                        baud_reg  <= '0;
                        tx_reg    <= 1'b1;
                        state_reg <= S_STOP;
                    end else begin
                        baud_reg <= baud_reg + BW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (baud_end) begin
                        baud_reg <= '0;
                        if (pop) begin
                            shift_reg  <= head_byte;
`ifdef UART_TX_PARITY_EN
                            parity_reg <= ^head_byte;
`endif
                            tx_reg     <= 1'b0;
                            state_reg  <= S_START;
                        end else begin
                            tx_reg    <= 1'b1;
                            state_reg <= S_IDLE;
                        end
                    end else begin
                        baud_reg <= baud_reg + BW'(1);
                    end
                end
                default: begin
                    baud_reg  <= '0;
                    tx_reg    <= 1'b1;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Tx   = tx_reg;
    assign o_busy = (state_reg != S_IDLE) || !fifo_empty;

    always_comb begin
        count_ext   = 8'(count_reg);
        status_word = {23'b0, PARITY_FLAG, count_ext[3:0], ovf_reg, fifo_empty, fifo_full, o_busy};
        bus.readData = 32'h0;
        if (status_sel) begin
            bus.readData = status_word;
        end
    end

    assign unused_bits = ^{bus.writeData[31:8], count_ext[7:4]};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: every cycle compares o_Tx, o_busy and STATUS
// against a queue-based frame-timeline model of the peripheral.
module tb_uart_tx_mmio;

    localparam int          CPB    = 4;
    localparam int          DEPTH  = 4;
    localparam logic [15:0] DATA_A = 16'hFF00;
    localparam logic [15:0] STAT_A = 16'hFF04;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int NBITS = 10;
    localparam bit PAR   = 1'b0;
`endif
    localparam int FRAME = NBITS * CPB;

    logic clk = 1'b0;
    logic rst_n;
    logic o_tx;
    logic o_busy;

    uart_tx_mmio_if bus ();

    uart_tx_mmio #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .BASE_ADDR    (16'hFF00)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .o_Tx   (o_tx),
        .o_busy (o_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending bytes, the byte on the line and when it was taken.
    logic [7:0] mq[$];
    logic [7:0] m_cur = 8'h00;
    bit         m_ovf = 1'b0;
    int         m_cyc = 0;
    int         m_last_pop = -1000;
    int         m_next_pop = 0;

    function automatic logic exp_tx();
        int k;
        int idx;
        k = m_cyc - m_last_pop;
        if (k < 0 || k >= FRAME) return 1'b1;
        idx = k / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_cur[idx-1];
        if (PAR && idx == 9) return ^m_cur;
        return 1'b1;
    endfunction

    function automatic logic exp_busy();
        return (mq.size() > 0) || ((m_cyc - m_last_pop) < FRAME);
    endfunction

    function automatic logic [31:0] exp_status();
        int cnt;
        cnt = mq.size();
        return {23'b0, PAR, 4'(cnt), m_ovf, (cnt == 0), (cnt == DEPTH), exp_busy()};
    endfunction

    task automatic model_clock(input bit rst, input bit we, input logic [15:0] a, input logic [31:0] d);
        int sz;
        m_cyc++;
        if (rst) begin
            mq.delete();
            m_ovf      = 1'b0;
            m_last_pop = -1000;
            m_next_pop = 0;
        end else begin
            sz = mq.size();
            if (sz > 0 && m_cyc >= m_next_pop) begin
                m_cur      = mq.pop_front();
                m_last_pop = m_cyc;
                m_next_pop = m_cyc + FRAME;
            end
            if (we && a == DATA_A) begin
                if (sz == DEPTH) m_ovf = 1'b1;
                else mq.push_back(d[7:0]);
            end
            if (we && a == STAT_A && d[3]) m_ovf = 1'b0;
        end
    endtask

    // Apply inputs for one edge, advance the model, then leave the bus addressing STATUS.
    task automatic drive_edge(input bit rst, input bit we, input logic [15:0] a, input logic [31:0] d);
        rst_n         = !rst;
        bus.WE        = we;
        bus.address   = a;
        bus.writeData = d;
        @(posedge clk);
        #1;
        model_clock(rst, we, a, d);
        rst_n         = 1'b1;
        bus.WE        = 1'b0;
        bus.address   = STAT_A;
        bus.writeData = 32'h0;
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] other;
        for (int i = 0; i < 3; i++) drive_edge(1'b1, 1'b0, 16'h0, 32'h0);
        n_checks++;
        if (o_tx !== 1'b1) begin
            n_fail++; $display("FAIL reset_tx got=%b exp=1", o_tx);
        end
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got=%b exp=0", o_busy);
        end
        n_checks++;
        if (bus.readData !== (32'h4 | (32'(PAR) << 8))) begin
            n_fail++; $display("FAIL reset_status got=%h exp=%h", bus.readData, 32'h4 | (32'(PAR) << 8));
        end
        bus.address = DATA_A;
        #1;
        n_checks++;
        if (bus.readData !== 32'h0) begin
            n_fail++; $display("FAIL data_read got=%h exp=0", bus.readData);
        end
        other = 16'($urandom_range(0, 16'hFEFF));
        bus.address = other;
        #1;
        n_checks++;
        if (bus.readData !== 32'h0) begin
            n_fail++; $display("FAIL unmapped_read addr=%h got=%h exp=0", other, bus.readData);
        end
        bus.address = STAT_A;
    endtask

    task automatic test_single_byte();
        drive_edge(1'b0, 1'b1, DATA_A, {24'($urandom), 8'hA5});
        for (int j = 0; j <= FRAME + 4; j++) begin
            if (j > 0) drive_edge(1'b0, 1'b0, STAT_A, 32'h0);
            n_checks++;
            if (o_tx !== exp_tx()) begin
                n_fail++; $display("FAIL single_tx j=%0d got=%b exp=%b", j, o_tx, exp_tx());
            end
            n_checks++;
            if (o_busy !== exp_busy()) begin
                n_fail++; $display("FAIL single_busy j=%0d got=%b exp=%b", j, o_busy, exp_busy());
            end
            n_checks++;
            if (bus.readData !== exp_status()) begin
                n_fail++; $display("FAIL single_status j=%0d got=%h exp=%h", j, bus.readData, exp_status());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [4];
        int n;
        b[0] = 8'h01; b[1] = 8'h02; b[2] = 8'($urandom); b[3] = 8'($urandom);
        for (int round = 0; round < 2; round++) begin
            n = (round == 0) ? 2 : 4;
            for (int j = 0; j < n * FRAME + 4; j++) begin
                if (j < n) drive_edge(1'b0, 1'b1, DATA_A, {24'h0, b[j]});
                else drive_edge(1'b0, 1'b0, STAT_A, 32'h0);
                n_checks++;
                if (o_tx !== exp_tx()) begin
                    n_fail++; $display("FAIL b2b_tx r=%0d j=%0d got=%b exp=%b", round, j, o_tx, exp_tx());
                end
                n_checks++;
                if (o_busy !== exp_busy()) begin
                    n_fail++; $display("FAIL b2b_busy r=%0d j=%0d got=%b exp=%b", round, j, o_busy, exp_busy());
                end
                n_checks++;
                if (bus.readData !== exp_status()) begin
                    n_fail++; $display("FAIL b2b_status r=%0d j=%0d got=%h exp=%h", round, j, bus.readData, exp_status());
                end
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) begin
            drive_edge(1'b0, 1'b1, DATA_A, 32'($urandom));
            n_checks++;
            if (bus.readData !== exp_status()) begin
                n_fail++; $display("FAIL ovf_fill i=%0d got=%h exp=%h", i, bus.readData, exp_status());
            end
        end
        n_checks++;
        if (bus.readData !== (32'h4B | (32'(PAR) << 8))) begin
            n_fail++; $display("FAIL ovf_status got=%h exp=%h", bus.readData, 32'h4B | (32'(PAR) << 8));
        end
        drive_edge(1'b0, 1'b1, STAT_A, 32'h8);
        n_checks++;
        if (bus.readData !== (32'h43 | (32'(PAR) << 8))) begin
            n_fail++; $display("FAIL ovf_clear got=%h exp=%h", bus.readData, 32'h43 | (32'(PAR) << 8));
        end
        for (int j = 0; j < 5 * FRAME; j++) begin
            drive_edge(1'b0, 1'b0, STAT_A, 32'h0);
            n_checks++;
            if (o_tx !== exp_tx()) begin
                n_fail++; $display("FAIL ovf_tx j=%0d got=%b exp=%b", j, o_tx, exp_tx());
            end
            n_checks++;
            if (bus.readData !== exp_status()) begin
                n_fail++; $display("FAIL ovf_drain_status j=%0d got=%h exp=%h", j, bus.readData, exp_status());
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        drive_edge(1'b0, 1'b1, DATA_A, 32'hFF);
        // 17 edges later the line is inside data bit 3.
        for (int j = 0; j < 17; j++) begin
            drive_edge(1'b0, 1'b0, STAT_A, 32'h0);
            n_checks++;
            if (o_tx !== exp_tx()) begin
                n_fail++; $display("FAIL midrst_pre_tx j=%0d got=%b exp=%b", j, o_tx, exp_tx());
            end
        end
        drive_edge(1'b0, 1'b1, DATA_A, 32'h3C);
        drive_edge(1'b1, 1'b0, STAT_A, 32'h0);
        n_checks++;
        if (o_tx !== 1'b1) begin
            n_fail++; $display("FAIL midrst_tx got=%b exp=1", o_tx);
        end
        for (int j = 0; j < FRAME + 10; j++) begin
            drive_edge(1'b0, 1'b0, STAT_A, 32'h0);
            n_checks++;
            if (o_tx !== 1'b1 || o_busy !== 1'b0) begin
                n_fail++; $display("FAIL midrst_idle j=%0d tx=%b busy=%b exp tx=1 busy=0", j, o_tx, o_busy);
            end
            n_checks++;
            if (bus.readData !== exp_status()) begin
                n_fail++; $display("FAIL midrst_status j=%0d got=%h exp=%h", j, bus.readData, exp_status());
            end
        end
    endtask

    task automatic test_random();
        int r;
        for (int j = 0; j < 600 + 6 * FRAME; j++) begin
            r = (j < 600) ? $urandom_range(0, 99) : 99;
            if (r < 10) drive_edge(1'b0, 1'b1, DATA_A, 32'($urandom));
            else if (r < 13) drive_edge(1'b0, 1'b1, STAT_A, 32'($urandom));
            else if (r < 16) drive_edge(1'b0, 1'b1, 16'(16'h1000 + $urandom_range(0, 255)), 32'($urandom));
            else if (r == 16) drive_edge(1'b1, 1'b0, STAT_A, 32'h0);
            else drive_edge(1'b0, 1'b0, STAT_A, 32'h0);
            n_checks++;
            if (o_tx !== exp_tx()) begin
                n_fail++; $display("FAIL rand_tx j=%0d got=%b exp=%b", j, o_tx, exp_tx());
            end
            n_checks++;
            if (o_busy !== exp_busy()) begin
                n_fail++; $display("FAIL rand_busy j=%0d got=%b exp=%b", j, o_busy, exp_busy());
            end
            n_checks++;
            if (bus.readData !== exp_status()) begin
                n_fail++; $display("FAIL rand_status j=%0d got=%h exp=%h", j, bus.readData, exp_status());
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        drive_edge(1'b0, 1'b1, DATA_A, 32'h07);
        for (int j = 1; j <= FRAME + 2; j++) begin
            drive_edge(1'b0, 1'b0, STAT_A, 32'h0);
            n_checks++;
            if (o_tx !== exp_tx()) begin
                n_fail++; $display("FAIL parity_tx j=%0d got=%b exp=%b", j, o_tx, exp_tx());
            end
            if (j == 1 + 9 * CPB) begin
                n_checks++;
                if (o_tx !== 1'b1) begin
                    n_fail++; $display("FAIL parity_bit got=%b exp=1", o_tx);
                end
            end
            n_checks++;
            if (o_busy !== (j <= FRAME)) begin
                n_fail++; $display("FAIL parity_busy j=%0d got=%b exp=%b", j, o_busy, j <= FRAME);
            end
        end
        n_checks++;
        if (bus.readData[8] !== 1'b1) begin
            n_fail++; $display("FAIL parity_flag got=%b exp=1", bus.readData[8]);
        end
    endtask
`endif

    initial begin
        rst_n         = 1'b0;
        bus.WE        = 1'b0;
        bus.address   = 16'h0;
        bus.writeData = 32'h0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
